// File: rtl/data_memory_ctrl.sv
// Load/store data memory: word RAM with byte lanes, valid/ready request port,
// programmable wait states, one-cycle response. Optional macro DMEM_MISALIGN_EN.
module data_memory_ctrl #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DEPTH_LOG2+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int unsigned AW    = DEPTH_LOG2 + 2;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CW    = 4;
   localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES == 0) ? CW'(0) : CW'(WAIT_STATES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   typedef struct packed {
      logic          we;
      logic [1:0]    size;
      logic          uns;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
   } req_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   req_t            lat_q;
   req_t            cur_c;
   logic [31:0]     mem [DEPTH];

   logic            acc_c;
   logic            err_c;
   logic            wr_c;
   logic [1:0]      lane_c;
   logic [3:0]      be_c;
   logic [31:0]     wd_c;
   logic [31:0]     rd_word_c;
   logic [7:0]      rd_byte_c;
   logic [15:0]     rd_half_c;
   logic [31:0]     load_c;

   // With zero wait states the access uses the live request, otherwise the latched one.
   always_comb begin
      cur_c = lat_q;
      if (state_q == ST_IDLE) begin
         cur_c.we    = req_we;
         cur_c.size  = req_size;
         cur_c.uns   = req_unsigned;
         cur_c.addr  = req_addr;
         cur_c.wdata = req_wdata;
      end
   end

   assign acc_c  = ((state_q == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                   ((state_q == ST_WAIT) && (cnt_q == '0));
   assign lane_c = cur_c.addr[1:0];

`ifdef DMEM_MISALIGN_EN
   assign err_c = (cur_c.size == 2'b11) ||
                  ((cur_c.size == 2'b01) && lane_c[0]) ||
                  ((cur_c.size == 2'b10) && (lane_c != 2'b00));
`else
   assign err_c = (cur_c.size == 2'b11);
`endif

   assign wr_c = acc_c && !rst && !err_c && cur_c.we;

   // Byte enables and lane-replicated write data.
   always_comb begin
      be_c = 4'b0000;
      wd_c = cur_c.wdata;
      case (cur_c.size)
         2'b00: begin
            be_c = 4'(4'b0001 << lane_c);
            wd_c = {4{cur_c.wdata[7:0]}};
         end
         2'b01: begin
            be_c = lane_c[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{cur_c.wdata[15:0]}};
         end
         2'b10:   be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
   end

   assign rd_word_c = mem[cur_c.addr[AW-1:2]];
   assign rd_byte_c = 8'(rd_word_c >> {lane_c, 3'b000});
   assign rd_half_c = 16'(rd_word_c >> {lane_c[1], 4'b0000});

   always_comb begin
      load_c = 32'h0;
      case (cur_c.size)
         2'b00:   load_c = cur_c.uns ? {24'h0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
         2'b01:   load_c = cur_c.uns ? {16'h0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
         2'b10:   load_c = rd_word_c;
         default: load_c = 32'h0;
      endcase
   end

   // Array storage is not reset.
   always_ff @(posedge clk) begin
      if (wr_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[cur_c.addr[AW-1:2]][8*i +: 8] <= wd_c[8*i +: 8];
         end
      end
   end

   // Control FSM and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lat_q     <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_q     <= cur_c;
                  req_ready <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state_q   <= ST_RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q   <= ST_RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ST_RESP: begin
               state_q   <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state_q   <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
         if (acc_c) begin
            rsp_err   <= err_c;
            rsp_rdata <= (err_c || cur_c.we) ? 32'h0 : load_c;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: three instances with 0, 3 and 2
// wait states; honours DMEM_MISALIGN_EN when defined.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic        rv0, rv1, rv2;
   logic        rdy0, rdy1, rdy2;
   logic        vld0, vld1, vld2;
   logic [31:0] rd0, rd1, rd2;
   logic        er0, er1, er2;

   int          cur;
   logic        s_ready, s_valid, s_err;
   logic [31:0] s_rdata;

   int checks = 0;
   int errors = 0;

`ifdef DMEM_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_w0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(er0));

   data_memory_ctrl #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u_w3 (
      .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(er1));

   data_memory_ctrl #(.DEPTH_LOG2(8), .WAIT_STATES(2)) u_w2 (
      .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rdy2), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .rsp_valid(vld2), .rsp_rdata(rd2), .rsp_err(er2));

   always_comb begin
      s_ready = rdy0; s_valid = vld0; s_rdata = rd0; s_err = er0;
      if (cur == 1) begin
         s_ready = rdy1; s_valid = vld1; s_rdata = rd1; s_err = er1;
      end else if (cur == 2) begin
         s_ready = rdy2; s_valid = vld2; s_rdata = rd2; s_err = er2;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic set_valid(input int d, input logic v);
      case (d)
         0:       rv0 = v;
         1:       rv1 = v;
         default: rv2 = v;
      endcase
   endtask

   task automatic drive(input logic w, input logic [1:0] s, input logic u,
                        input logic [9:0] a, input logic [31:0] wd);
      we = w; size = s; uns = u; addr = a; wdata = wd;
   endtask

   // One request on instance d; checks latency, read data and error flag.
   task automatic do_req(input string nm, input int d, input int ws,
                         input logic w, input logic [1:0] s, input logic u,
                         input logic [9:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_er);
      int n;
      bit got;
      cur = d;
      @(negedge clk);
      drive(w, s, u, a, wd);
      chk({nm, " ready"}, 32'(s_ready), 32'd1);
      set_valid(d, 1'b1);
      @(posedge clk);
      #1 set_valid(d, 1'b0);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (s_valid) got = 1'b1;
      end
      chk({nm, " latency"}, 32'(n), 32'(ws + 1));
      chk({nm, " rdata"}, s_rdata, exp_rd);
      chk({nm, " err"}, 32'(s_err), 32'(exp_er));
   endtask

   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

   initial begin
      vecs[0]  = '{1'b1, W, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, W, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, W, 1'b0, 10'h020, 32'h11223344, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, B, 1'b0, 10'h022, 32'h123456A5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, B, 1'b0, 10'h022, 32'h0,        32'hFFFFFFA5, 1'b0};
      vecs[5]  = '{1'b0, B, 1'b1, 10'h022, 32'h0,        32'h000000A5, 1'b0};
      vecs[6]  = '{1'b0, W, 1'b0, 10'h020, 32'h0,        32'h11A53344, 1'b0};
      vecs[7]  = '{1'b1, W, 1'b0, 10'h030, 32'hAAAA5555, 32'h0,        1'b0};
      vecs[8]  = '{1'b1, H, 1'b0, 10'h032, 32'hFFFF8001, 32'h0,        1'b0};
      vecs[9]  = '{1'b0, H, 1'b0, 10'h032, 32'h0,        32'hFFFF8001, 1'b0};
      vecs[10] = '{1'b0, H, 1'b1, 10'h032, 32'h0,        32'h00008001, 1'b0};
      vecs[11] = '{1'b0, W, 1'b0, 10'h030, 32'h0,        32'h80015555, 1'b0};
      vecs[12] = '{1'b0, B, 1'b0, 10'h033, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[13] = '{1'b0, W, 1'b1, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[14] = '{1'b1, W, 1'b0, 10'h040, 32'h01020304, 32'h0,        1'b0};
      vecs[15] = '{1'b1, W, 1'b0, 10'h041, 32'hCAFEF00D, 32'h0,        MIS};
      vecs[16] = '{1'b0, W, 1'b0, 10'h040, 32'h0, MIS ? 32'h01020304 : 32'hCAFEF00D, 1'b0};
      vecs[17] = '{1'b0, H, 1'b1, 10'h033, 32'h0, MIS ? 32'h0 : 32'h00008001, MIS};
      vecs[18] = '{1'b1, R, 1'b0, 10'h040, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[19] = '{1'b0, W, 1'b0, 10'h040, 32'h0, MIS ? 32'h01020304 : 32'hCAFEF00D, 1'b0};
      vecs[20] = '{1'b0, R, 1'b0, 10'h040, 32'h0,        32'h0,        1'b1};

      cur = 0;
      rst = 1'b1;
      rv0 = 1'b0; rv1 = 1'b0; rv2 = 1'b0;
      drive(1'b0, B, 1'b0, 10'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         cur = d;
         #0;
         chk($sformatf("reset ready d%0d", d), 32'(s_ready), 32'd1);
         chk($sformatf("reset valid d%0d", d), 32'(s_valid), 32'd0);
         chk($sformatf("reset rdata d%0d", d), s_rdata, 32'h0);
         chk($sformatf("reset err d%0d", d), 32'(s_err), 32'd0);
      end

      // Zero-wait-state vector table.
      for (int i = 0; i < 21; i++) begin
         do_req($sformatf("vec%0d", i), 0, 0, vecs[i].we, vecs[i].size, vecs[i].uns,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      end

      // Three wait states with req_valid held high.
      do_req("w3 store", 1, 3, 1'b1, W, 1'b0, 10'h060, 32'h0BADF00D, 32'h0, 1'b0);
      cur = 1;
      @(negedge clk);
      drive(1'b0, W, 1'b0, 10'h060, 32'h0);
      rv1 = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("held ready k%0d", k), 32'(s_ready), 32'((k % 5) == 0));
         chk($sformatf("held valid k%0d", k), 32'(s_valid), 32'((k % 5) == 4));
         if ((k % 5) == 4) chk($sformatf("held rdata k%0d", k), s_rdata, 32'h0BADF00D);
      end
      rv1 = 1'b0;
      repeat (6) @(negedge clk);

      // Reset during WAIT drops the store.
      do_req("w2 clear", 2, 2, 1'b1, W, 1'b0, 10'h050, 32'h0, 32'h0, 1'b0);
      cur = 2;
      @(negedge clk);
      drive(1'b1, W, 1'b0, 10'h050, 32'h12345678);
      rv2 = 1'b1;
      @(posedge clk);
      #1 rv2 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst valid", 32'(s_valid), 32'd0);
      chk("midrst ready", 32'(s_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("midrst quiet k%0d", k), 32'(s_valid), 32'd0);
      end
      do_req("midrst load", 2, 2, 1'b0, W, 1'b0, 10'h050, 32'h0, 32'h0, 1'b0);

      // Reset coinciding with the access edge blocks the write.
      cur = 2;
      @(negedge clk);
      drive(1'b1, W, 1'b0, 10'h050, 32'h12345678);
      rv2 = 1'b1;
      @(posedge clk);
      #1 rv2 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("accrst valid", 32'(s_valid), 32'd0);
      chk("accrst ready", 32'(s_ready), 32'd1);
      do_req("accrst load", 2, 2, 1'b0, W, 1'b0, 10'h050, 32'h0, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Next-generation data memory for the RISC-V core's load/store path. Word-organised RAM of parametrised depth with a valid/ready request port and a one-cycle response pulse. Supports byte, half-word and word stores through byte lanes, and sign/zero-extended sub-word loads. Programmable wait states emulate slower memories behind the LSU.

Parameters:
DEPTH_LOG2, 8, log2 of word count (default 256 words = 1 KiB)
WAIT_STATES, 0, extra cycles between request acceptance and the array access (0..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  DEPTH_LOG2+2  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  valid with rsp_valid; request rejected, no side effects

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset does not clear array contents.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid at edge E0; latch we, size, unsigned, addr and wdata.
  - If WAIT_STATES=0: perform the access at E0 and go to RESP.
  - Otherwise: go to WAIT with counter=WAIT_STATES-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge. At the edge where the counter is 0, perform the access and go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0.
  - Next edge returns to IDLE.
  - No response backpressure.
- Latency: rsp_valid is high in the cycle after edge E0+WAIT_STATES. Throughput is one request per WAIT_STATES+2 cycles.
- Inputs are ignored outside IDLE. A req_valid held during WAIT/RESP is not accepted until the next IDLE cycle.
- Word index = addr[DEPTH_LOG2+1:2]. Lane = addr[1:0].
- Stores:
  - Byte: wdata[7:0] written to lane addr[1:0].
  - Half: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes written.
  - Unaddressed lanes are unchanged. rsp_rdata=0.
- Loads:
  - Extract the addressed byte/half/word from the stored word.
  - Sign-extend from bit 7/15 unless latched unsigned=1.
  - Word loads ignore unsigned.
  - rsp_rdata is registered at the access edge and held until the next access edge.
- Reserved size 11: rsp_err=1, no write, rsp_rdata=0, same latency.
- Reset mid-operation: any accepted but unanswered request is dropped. If rst coincides with the access edge, reset wins and no write occurs.
- Read of a never-written word returns X in simulation. The bench must write before reading.

Optional Feature:
Macro DMEM_MISALIGN_EN.
- Defined: misaligned requests (half with addr[0]=1, or word with addr[1:0]!=0) complete with rsp_err=1, no write and rsp_rdata=0, at normal latency.
- Undefined: no misalignment check.
  - Half accesses ignore addr[0].
  - Word accesses ignore addr[1:0].
  - rsp_err is raised only for size 11.

Test Plan:
1. Word store 0xDEADBEEF @0x010, then word load @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; with WAIT_STATES=0, rsp_valid is high the cycle after each accept.
2. Word store 0x11223344 @0x020; byte store 0xA5 @0x022; signed byte load @0x022 -> 0xFFFFFFA5; unsigned byte load @0x022 -> 0x000000A5; word load @0x020 -> 0x11A53344.
3. Half store 0x8001 @0x032; signed half load @0x032 -> 0xFFFF8001; unsigned -> 0x00008001; word load @0x030 shows lower half unchanged.
4. WAIT_STATES=3, req_valid held high continuously -> rsp_valid exactly 4 cycles after each accept edge; req_ready low for 4 cycles between accepts; second request accepted only after the RESP cycle.
5. Word store @0x041 -> with DMEM_MISALIGN_EN: rsp_err=1 and word @0x040 unchanged; without it: store lands at 0x040, rsp_err=0. Size 11 -> rsp_err=1 in both builds.
6. WAIT_STATES=2: store 0x12345678 @0x050 (previously 0), assert rst for one cycle during WAIT -> no rsp_valid, state IDLE, req_ready=1 next cycle, load @0x050 returns 0x00000000.
